// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB-first, start/done handshake
// Optional overflow output v is compiled in with SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         b
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         v
`endif
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  xs;
    logic [W-1:0]  ys;
    logic          br;
    logic [CW-1:0] cnt;
    logic          sum_bit;
    logic          br_next;

`ifdef SERIAL_SUB_OVF_EN
    logic          x_msb;
    logic          y_msb;
`endif

    // Full-subtractor cell, reused once per bit position.
    assign sum_bit = xs[0] ^ ys[0] ^ br;
    assign br_next = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & br);

    // The minuend register doubles as the difference shift register: difference
    // bits enter at the MSB while unused minuend bits leave at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            xs    <= '0;
            ys    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            b     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb <= 1'b0;
            y_msb <= 1'b0;
            v     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xs    <= x;
                        ys    <= y;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        x_msb <= x[W-1];
                        y_msb <= y[W-1];
`endif
                    end
                end
                S_SHIFT: begin
                    xs  <= {sum_bit, xs[W-1:1]};
                    ys  <= ys >> 1;
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= {sum_bit, xs[W-1:1]};
                        b     <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        v     <= (x_msb ^ y_msb) & (sum_bit ^ x_msb);
`endif
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (W=8 and W=4)
module tb_serial_subtractor;
    logic       clk;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] x8, y8, d8;
    logic [3:0] x4, y4, d4;
    logic       busy8, done8, b8, busy4, done4, b4;
`ifdef SERIAL_SUB_OVF_EN
    logic       v8, v4;
`endif

    int n_vec;
    int n_err;
    int cyc;
    logic [7:0] last_d;
    logic       last_b;
    logic       last_v;

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .d(d8), .b(b8)
`ifdef SERIAL_SUB_OVF_EN
        , .v(v8)
`endif
    );

    serial_subtractor #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .d(d4), .b(b4)
`ifdef SERIAL_SUB_OVF_EN
        , .v(v4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One W=8 operation with full cycle-by-cycle checks; poke>=0 pulses start
    // with x=y=1 during that SHIFT cycle, which must be ignored.
    task automatic op8(input logic [7:0] a, input logic [7:0] c, input int poke);
        logic [7:0] exp_d;
        logic       exp_b;
        logic       exp_v;
        int         sdiff;
        exp_d = 8'((int'(a) - int'(c)) % 256);
        exp_b = (a < c);
        sdiff = int'($signed(a)) - int'($signed(c));
        exp_v = (sdiff > 127) || (sdiff < -128);
        @(negedge clk);
        start8 = 1'b1; x8 = a; y8 = c;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
            end else begin
                start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
            end
            n_vec++;
            if (busy8 !== 1'b1 || done8 !== 1'b0 || d8 !== last_d) begin
                n_err++;
                $display("FAIL shift_phase k=%0d busy=%b done=%b d=%h required busy=1 done=0 d=%h",
                         k, busy8, done8, d8, last_d);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        n_vec++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || d8 !== exp_d || b8 !== exp_b) begin
            n_err++;
            $display("FAIL result %0d-%0d done=%b busy=%b d=%h b=%b required done=1 busy=0 d=%h b=%b",
                     a, c, done8, busy8, d8, b8, exp_d, exp_b);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_vec++;
        if (v8 !== exp_v) begin
            n_err++;
            $display("FAIL overflow %h-%h v=%b required %b", a, c, v8, exp_v);
        end
`endif
        @(negedge clk);
        n_vec++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || d8 !== exp_d || b8 !== exp_b) begin
            n_err++;
            $display("FAIL after_done done=%b busy=%b d=%h b=%b required done=0 busy=0 d=%h b=%b",
                     done8, busy8, d8, b8, exp_d, exp_b);
        end
        last_d = exp_d; last_b = exp_b; last_v = exp_v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || d8 !== 8'h00 || b8 !== 1'b0 ||
            busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 4'h0 || b4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state busy=%b done=%b d=%h b=%b required all zero", busy8, done8, d8, b8);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_vec++;
        if (v8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_v v=%b required 0", v8);
        end
`endif
        rst_n = 1'b1;
        last_d = '0; last_b = 1'b0; last_v = 1'b0;
    endtask

    task automatic test_directed();
        op8(8'd100, 8'd37, -1);
        op8(8'h00, 8'h01, -1);
        op8(8'h80, 8'h01, -1);
        op8(8'h00, 8'hFF, -1);
        op8(8'hFF, 8'h00, -1);
        op8(8'hA5, 8'hA5, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x8 = 8'($urandom); y8 = 8'($urandom);
            n_vec++;
            if (d8 !== 8'h00 || b8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold i=%0d d=%h b=%b done=%b busy=%b required d=00 b=0 done=0 busy=0",
                         i, d8, b8, done8, busy8);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) op8(8'($urandom), 8'($urandom), -1);
    endtask

    task automatic test_start_ignored();
        op8(8'd100, 8'd37, 3);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start8 = 1'b1; x8 = 8'd200; y8 = 8'd13;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy8 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre busy=%b required 1", busy8);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || d8 !== 8'h00 || b8 !== 1'b0) begin
            n_err++;
            $display("FAIL async_abort busy=%b done=%b d=%h b=%b required all zero", busy8, done8, d8, b8);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            n_vec++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_done i=%0d done=%b busy=%b required 0 0", i, done8, busy8);
            end
        end
        last_d = '0; last_b = 1'b0; last_v = 1'b0;
        op8(8'd9, 8'd4, -1);
    endtask

    task automatic test_back_to_back();
        int idx;
        int last_cyc;
        int waited;
        logic [3:0] ex_x, ex_y;
        idx = 0;
        last_cyc = 0;
        @(negedge clk);
        start4 = 1'b1; x4 = 4'd0; y4 = 4'd0;
        while (idx < 256) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (done4 !== 1'b1 && waited < 20);
            if (done4 !== 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL b2b_timeout idx=%0d no done within 20 cycles", idx);
                break;
            end
            ex_x = 4'(idx / 16);
            ex_y = 4'(idx % 16);
            n_vec++;
            if (d4 !== 4'((int'(ex_x) + 16 - int'(ex_y)) % 16) || b4 !== (ex_x < ex_y)) begin
                n_err++;
                $display("FAIL b2b_result %0d-%0d d=%h b=%b required d=%h b=%b", ex_x, ex_y, d4, b4,
                         4'((int'(ex_x) + 16 - int'(ex_y)) % 16), ex_x < ex_y);
            end
            if (idx > 0) begin
                n_vec++;
                if (cyc - last_cyc !== 6) begin
                    n_err++;
                    $display("FAIL b2b_spacing idx=%0d spacing=%0d required 6", idx, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            idx++;
            if (idx < 256) begin
                x4 = 4'(idx / 16); y4 = 4'(idx % 16);
            end else begin
                start4 = 1'b0;
            end
        end
        start4 = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        start8 = 1'b0; start4 = 1'b0;
        x8 = '0; y8 = '0; x4 = '0; y4 = '0;
        last_d = '0; last_b = 1'b0; last_v = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
